// File: rtl/row_reader_pkg.sv
// Shared types and defaults for the row-address consumer: FSM states,
// default geometry, and the flag bundle that travels with each pixel.
package row_reader_pkg;

  localparam int DEF_COLS   = 1280;
  localparam int DEF_ROWS   = 720;
  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 24;
  localparam int ROW_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Pixel markers; a FIFO entry is {pix_flags_t, pixel data}.
  typedef struct packed {
    logic eof;
    logic eol;
    logic sol;
  } pix_flags_t;

  localparam int FLAG_W = $bits(pix_flags_t);

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO with a registered head; entry 0 is always the head so the
// output never depends combinationally on push or pop.
module pix_skid_fifo #(
  parameter int W = 27
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_occ,
  output logic         o_valid
);

  logic [W-1:0] r_e0;
  logic [W-1:0] r_e1;
  logic [1:0]   r_occ;

  // Callers never push into a full FIFO without popping in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_occ <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_e0 <= i_push_data;
          else               r_e1 <= i_push_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_e0 <= i_push_data;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_e0;
  assign o_occ   = r_occ;
  assign o_valid = (r_occ != 2'd0);

endmodule

// File: rtl/row_pixel_reader.sv
// Accepts row addresses, reads the row from frame memory (1-cycle latency)
// and streams the pixels out with sol/eol/eof markers under backpressure.
module row_pixel_reader
  import row_reader_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ROW_W-1:0]  i_row_addr,
  input  logic              i_row_valid,
  output logic              o_row_ready,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_pix_data,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic              o_pix_sol,
  output logic              o_pix_eol,
  output logic              o_pix_eof,
  output logic              o_err_range,
  output state_t            o_dbg_state
);

  localparam int COL_W = $clog2(COLS);
  localparam int ENT_W = DATA_W + FLAG_W;
  localparam int RW1   = ROW_W + 1;
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [RW1-1:0]    ROWS_L   = RW1'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [COL_W-1:0]  r_col;
  logic              r_eof_row;
  logic              r_infl;
  pix_flags_t        r_infl_flags;
  logic              r_err;

  logic [ENT_W-1:0]  w_head;
  logic [1:0]        w_occ;
  logic              w_pix_valid;
  pix_flags_t        w_head_flags;
  pix_flags_t        w_rd_flags;
  logic              w_pop;
  logic [2:0]        w_pend;
  logic              w_rd;
  logic              w_in_range;

  // Both streams transfer on a rising edge where valid and ready are high;
  // a raised pix_valid holds data and flags until pix_ready takes them.
  assign w_pop      = w_pix_valid & i_pix_ready;
  assign w_pend     = {1'b0, w_occ} + {2'b00, r_infl};
  assign w_rd       = (r_state == ST_FETCH) &&
                      ((w_pend <= 3'd1) || ((w_pend == 3'd2) && w_pop));
  assign w_in_range = ({1'b0, i_row_addr} < ROWS_L);

  always_comb begin
    w_rd_flags     = '0;
    w_rd_flags.sol = (r_col == '0);
    w_rd_flags.eol = (r_col == LAST_COL);
    w_rd_flags.eof = (r_col == LAST_COL) && r_eof_row;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_col        <= '0;
      r_eof_row    <= 1'b0;
      r_infl       <= 1'b0;
      r_infl_flags <= '0;
      r_err        <= 1'b0;
    end else begin
      r_infl <= w_rd;
      if (w_rd) r_infl_flags <= w_rd_flags;
      case (r_state)
        ST_IDLE: begin
          if (i_row_valid) begin
            if (w_in_range) begin
              r_base    <= ADDR_W'(i_row_addr) * COLS_A;
              r_col     <= '0;
              r_eof_row <= (i_row_addr == LAST_ROW);
              r_state   <= ST_FETCH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (w_rd) begin
            if (r_col == LAST_COL) begin
              r_col   <= '0;
              r_state <= ST_DRAIN;
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // eol is the final entry, so FIFO and read pipe are empty after it.
          if (w_pop && w_head_flags.eol) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pix_skid_fifo #(.W(ENT_W)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_infl),
    .i_push_data ({r_infl_flags, i_mem_rdata}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ),
    .o_valid     (w_pix_valid)
  );

  assign w_head_flags = pix_flags_t'(w_head[ENT_W-1:DATA_W]);

  assign o_row_ready = (r_state == ST_IDLE);
  assign o_mem_rd    = w_rd;
  assign o_mem_addr  = r_base + ADDR_W'(r_col);
  assign o_pix_data  = w_head[DATA_W-1:0];
  assign o_pix_valid = w_pix_valid;
  assign o_pix_sol   = w_head_flags.sol;
  assign o_pix_eol   = w_head_flags.eol;
  assign o_pix_eof   = w_head_flags.eof;
  assign o_err_range = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_row_pixel_reader.sv
// Bench for row_pixel_reader: memory model, observation monitor and a
// row-level reference that lists every address and pixel a row must produce.
module tb_row_pixel_reader;
  import row_reader_pkg::*;

  localparam int COLS   = 1280;
  localparam int ROWS   = 720;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 24;
  localparam int PW     = DATA_W + 3;

  logic              clk;
  logic              rst_n;
  logic [9:0]        row_addr;
  logic              row_valid;
  logic              row_ready;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sol, pix_eol, pix_eof;
  logic              err_range;
  state_t            dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [PW-1:0]     exp_q[$];
  logic [PW-1:0]     obs_pix_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [ADDR_W-1:0] obs_addr_q[$];
  int n_rd, n_pop, first_rd, first_pv, max_out, stab_err;
  bit            prev_hold;
  logic [PW-1:0] prev_word;
  logic [DATA_W-1:0] salt;

  row_pixel_reader #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_row_addr(row_addr), .i_row_valid(row_valid),
    .o_row_ready(row_ready), .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
    .i_mem_rdata(mem_rdata), .o_pix_data(pix_data), .o_pix_valid(pix_valid),
    .i_pix_ready(pix_ready), .o_pix_sol(pix_sol), .o_pix_eol(pix_eol),
    .o_pix_eof(pix_eof), .o_err_range(err_range), .o_dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[3:0], a} ^ salt;
  endfunction

  // frame memory: data for the strobed address arrives one cycle later
  always @(posedge clk) mem_rdata <= mem_rd ? mem_word(mem_addr) : DATA_W'($urandom);

  // monitor: records accepted reads and pixels, stability and outstanding depth
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) begin
        obs_addr_q.push_back(mem_addr);
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (pix_valid && first_pv < 0) first_pv = cyc;
      if (pix_valid && pix_ready) begin
        obs_pix_q.push_back({pix_eof, pix_eol, pix_sol, pix_data});
        n_pop++;
      end
      if (prev_hold && !(pix_valid && {pix_eof, pix_eol, pix_sol, pix_data} === prev_word))
        stab_err++;
      prev_hold = pix_valid && !pix_ready;
      prev_word = {pix_eof, pix_eol, pix_sol, pix_data};
      if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  // reference model: the full read and pixel sequence a row must produce
  task automatic build_row(input int row);
    for (int c = 0; c < COLS; c++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'(row * COLS + c);
      exp_addr_q.push_back(a);
      exp_q.push_back({(c == COLS-1 && row == ROWS-1), (c == COLS-1), (c == 0), mem_word(a)});
    end
  endtask

  task automatic clear_obs();
    exp_q.delete(); obs_pix_q.delete(); exp_addr_q.delete(); obs_addr_q.delete();
    n_rd = 0; n_pop = 0; first_rd = -1; first_pv = -1; max_out = 0; stab_err = 0;
  endtask

  // driver tasks
  task automatic apply_reset();
    rst_n = 1'b0; row_valid = 1'b0; row_addr = '0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic send_row(input logic [9:0] a, output int th, output bit to);
    to = 1'b1; th = 0;
    @(posedge clk); #1 row_valid = 1'b1; row_addr = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (row_ready) begin th = cyc + 1; to = 1'b0; break; end
    end
    @(posedge clk); #1 row_valid = 1'b0;
  endtask

  task automatic wait_row(input int mode, output bit to, output int rdy_cyc);
    to = 1'b1; rdy_cyc = 0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1 pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (row_ready) begin to = 1'b0; rdy_cyc = cyc; break; end
    end
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({row_ready, mem_rd, mem_addr, pix_valid, pix_data, pix_sol, pix_eol, pix_eof, err_range} !==
        {1'b1, 1'b0, {ADDR_W{1'b0}}, 1'b0, {DATA_W{1'b0}}, 4'b0000} || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_values got rdy=%b rd=%b addr=%0d pv=%b pd=%h flags=%b%b%b err=%b st=%0d want rdy=1 rest 0 st=0",
               row_ready, mem_rd, mem_addr, pix_valid, pix_data, pix_sol, pix_eol, pix_eof, err_range, dbg_state);
    end
  endtask

  task automatic test_row_first();
    int th, rc, bi; bit to, to2;
    clear_obs(); pix_ready = 1'b1; build_row(0);
    send_row(10'd0, th, to);
    wait_row(0, to2, rc);
    n_vec++; if (to || to2) begin n_err++; $display("FAIL row0_timeout got timeout want done"); end
    n_vec++; if (first_rd != th) begin n_err++; $display("FAIL row0_first_rd got cycle %0d want %0d", first_rd, th); end
    n_vec++; if (first_pv != th + 2) begin n_err++; $display("FAIL row0_first_pv got cycle %0d want %0d", first_pv, th + 2); end
    n_vec++; if (rc != th + 2 + COLS) begin n_err++; $display("FAIL row0_ready_back got cycle %0d want %0d", rc, th + 2 + COLS); end
    bi = -1;
    for (int i = 0; i < exp_addr_q.size(); i++) if (bi < 0 && (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i])) bi = i;
    if (bi < 0 && obs_addr_q.size() != exp_addr_q.size()) bi = exp_addr_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL row0_addr idx %0d got %0d reads want %0d reads (first bad addr got %0d)", bi, obs_addr_q.size(), exp_addr_q.size(), (bi < obs_addr_q.size()) ? obs_addr_q[bi] : '0); end
    bi = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bi < 0 && (i >= obs_pix_q.size() || obs_pix_q[i] !== exp_q[i])) bi = i;
    if (bi < 0 && obs_pix_q.size() != exp_q.size()) bi = exp_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL row0_pixels idx %0d got %h want %h (%0d of %0d)", bi, (bi < obs_pix_q.size()) ? obs_pix_q[bi] : '0, (bi < exp_q.size()) ? exp_q[bi] : '0, obs_pix_q.size(), exp_q.size()); end
  endtask

  task automatic test_last_row();
    int th, rc, bi; bit to, to2;
    clear_obs(); pix_ready = 1'b1; build_row(ROWS - 1);
    send_row(10'(ROWS - 1), th, to);
    wait_row(0, to2, rc);
    n_vec++; if (to || to2) begin n_err++; $display("FAIL row719_timeout got timeout want done"); end
    bi = -1;
    for (int i = 0; i < exp_addr_q.size(); i++) if (bi < 0 && (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i])) bi = i;
    if (bi < 0 && obs_addr_q.size() != exp_addr_q.size()) bi = exp_addr_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL row719_addr idx %0d got %0d reads want %0d reads", bi, obs_addr_q.size(), exp_addr_q.size()); end
    bi = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bi < 0 && (i >= obs_pix_q.size() || obs_pix_q[i] !== exp_q[i])) bi = i;
    if (bi < 0 && obs_pix_q.size() != exp_q.size()) bi = exp_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL row719_pixels idx %0d got %h want %h", bi, (bi < obs_pix_q.size()) ? obs_pix_q[bi] : '0, (bi < exp_q.size()) ? exp_q[bi] : '0); end
  endtask

  task automatic test_range_error();
    int th, rc, bi; bit to, to2;
    clear_obs(); pix_ready = 1'b1;
    send_row(10'(ROWS), th, to);
    @(negedge clk);
    n_vec++; if (to || row_ready !== 1'b1 || err_range !== 1'b1) begin n_err++; $display("FAIL range_handshake got to=%b rdy=%b err=%b want to=0 rdy=1 err=1", to, row_ready, err_range); end
    repeat (5) @(negedge clk);
    n_vec++; if (n_rd != 0) begin n_err++; $display("FAIL range_no_read got %0d reads want 0", n_rd); end
    clear_obs(); build_row(5);
    send_row(10'd5, th, to);
    wait_row(0, to2, rc);
    n_vec++; if (to || to2) begin n_err++; $display("FAIL range_row5_timeout got timeout want done"); end
    bi = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bi < 0 && (i >= obs_pix_q.size() || obs_pix_q[i] !== exp_q[i])) bi = i;
    if (bi < 0 && obs_pix_q.size() != exp_q.size()) bi = exp_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL range_row5_pixels idx %0d got %h want %h", bi, (bi < obs_pix_q.size()) ? obs_pix_q[bi] : '0, (bi < exp_q.size()) ? exp_q[bi] : '0); end
    n_vec++; if (err_range !== 1'b1) begin n_err++; $display("FAIL range_sticky got %b want 1", err_range); end
  endtask

  task automatic test_random_ready();
    int th, rc, bi; bit to, to2;
    clear_obs(); build_row(3);
    send_row(10'd3, th, to);
    wait_row(1, to2, rc);
    n_vec++; if (to || to2) begin n_err++; $display("FAIL rand_timeout got timeout want done"); end
    bi = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bi < 0 && (i >= obs_pix_q.size() || obs_pix_q[i] !== exp_q[i])) bi = i;
    if (bi < 0 && obs_pix_q.size() != exp_q.size()) bi = exp_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL rand_pixels idx %0d got %h want %h (%0d of %0d)", bi, (bi < obs_pix_q.size()) ? obs_pix_q[bi] : '0, (bi < exp_q.size()) ? exp_q[bi] : '0, obs_pix_q.size(), exp_q.size()); end
    n_vec++; if (max_out > 2) begin n_err++; $display("FAIL rand_outstanding got %0d want <=2", max_out); end
    n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL rand_stability got %0d changes want 0", stab_err); end
  endtask

  task automatic test_stall();
    int th, rc, bi; bit to, to2, seen; logic [PW-1:0] held;
    clear_obs(); pix_ready = 1'b0; build_row(200);
    send_row(10'd200, th, to);
    seen = 1'b0; held = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pix_valid) begin seen = 1'b1; held = {pix_eof, pix_eol, pix_sol, pix_data}; break; end
    end
    n_vec++; if (to || !seen) begin n_err++; $display("FAIL stall_first_valid got none want pix_valid"); end
    n_vec++; if (held !== exp_q[0]) begin n_err++; $display("FAIL stall_first_pixel got %h want %h", held, exp_q[0]); end
    repeat (10) @(negedge clk);
    n_vec++; if (n_rd != 2) begin n_err++; $display("FAIL stall_reads got %0d want 2", n_rd); end
    n_vec++; if (pix_valid !== 1'b1 || {pix_eof, pix_eol, pix_sol, pix_data} !== held) begin n_err++; $display("FAIL stall_hold got %b/%h want 1/%h", pix_valid, {pix_eof, pix_eol, pix_sol, pix_data}, held); end
    wait_row(0, to2, rc);
    n_vec++; if (to2) begin n_err++; $display("FAIL stall_timeout got timeout want done"); end
    bi = -1;
    for (int i = 0; i < exp_addr_q.size(); i++) if (bi < 0 && (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i])) bi = i;
    if (bi < 0 && obs_addr_q.size() != exp_addr_q.size()) bi = exp_addr_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL stall_addr idx %0d got %0d reads want %0d reads", bi, obs_addr_q.size(), exp_addr_q.size()); end
    bi = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bi < 0 && (i >= obs_pix_q.size() || obs_pix_q[i] !== exp_q[i])) bi = i;
    if (bi < 0 && obs_pix_q.size() != exp_q.size()) bi = exp_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL stall_pixels idx %0d got %h want %h", bi, (bi < obs_pix_q.size()) ? obs_pix_q[bi] : '0, (bi < exp_q.size()) ? exp_q[bi] : '0); end
    n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL stall_stability got %0d changes want 0", stab_err); end
  endtask

  task automatic test_back_to_back();
    int th, rc, bi, r; bit to, to2;
    clear_obs();
    for (int k = 0; k < 3; k++) begin
      r = $urandom_range(0, ROWS - 1);
      build_row(r);
      send_row(10'(r), th, to);
      wait_row(1, to2, rc);
      n_vec++; if (to || to2) begin n_err++; $display("FAIL b2b_timeout row %0d got timeout want done", r); end
    end
    bi = -1;
    for (int i = 0; i < exp_addr_q.size(); i++) if (bi < 0 && (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i])) bi = i;
    if (bi < 0 && obs_addr_q.size() != exp_addr_q.size()) bi = exp_addr_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL b2b_addr idx %0d got %0d reads want %0d reads", bi, obs_addr_q.size(), exp_addr_q.size()); end
    bi = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bi < 0 && (i >= obs_pix_q.size() || obs_pix_q[i] !== exp_q[i])) bi = i;
    if (bi < 0 && obs_pix_q.size() != exp_q.size()) bi = exp_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL b2b_pixels idx %0d got %h want %h", bi, (bi < obs_pix_q.size()) ? obs_pix_q[bi] : '0, (bi < exp_q.size()) ? exp_q[bi] : '0); end
    n_vec++; if (max_out > 2) begin n_err++; $display("FAIL b2b_outstanding got %0d want <=2", max_out); end
  endtask

  task automatic test_reset_mid_row();
    int th, rc, bi; bit to, to2;
    clear_obs(); pix_ready = 1'b1;
    send_row(10'd100, th, to);
    repeat (600) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({row_ready, mem_rd, mem_addr, pix_valid, pix_data, pix_sol, pix_eol, pix_eof, err_range} !==
        {1'b1, 1'b0, {ADDR_W{1'b0}}, 1'b0, {DATA_W{1'b0}}, 4'b0000} || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL midreset_values got rdy=%b rd=%b addr=%0d pv=%b pd=%h err=%b st=%0d want rdy=1 rest 0 st=0",
               row_ready, mem_rd, mem_addr, pix_valid, pix_data, err_range, dbg_state);
    end
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    clear_obs(); build_row(10);
    send_row(10'd10, th, to);
    wait_row(0, to2, rc);
    n_vec++; if (to || to2) begin n_err++; $display("FAIL midreset_timeout got timeout want done"); end
    n_vec++; if (obs_addr_q.size() == 0 || obs_addr_q[0] !== ADDR_W'(12800)) begin n_err++; $display("FAIL midreset_first_addr got %0d want 12800", (obs_addr_q.size() > 0) ? obs_addr_q[0] : '1); end
    bi = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bi < 0 && (i >= obs_pix_q.size() || obs_pix_q[i] !== exp_q[i])) bi = i;
    if (bi < 0 && obs_pix_q.size() != exp_q.size()) bi = exp_q.size();
    n_vec++; if (bi >= 0) begin n_err++; $display("FAIL midreset_pixels idx %0d got %h want %h (%0d of %0d)", bi, (bi < obs_pix_q.size()) ? obs_pix_q[bi] : '0, (bi < exp_q.size()) ? exp_q[bi] : '0, obs_pix_q.size(), exp_q.size()); end
  endtask

  initial begin
    salt = DATA_W'($urandom);
    apply_reset();
    test_reset();
    test_row_first();
    test_last_row();
    test_range_error();
    test_random_ready();
    test_stall();
    test_back_to_back();
    test_reset_mid_row();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
